// File: rtl/median_pkg.sv
// rtl/median_pkg.sv - shared constants for the rank-order filter result path
// Purpose: frame geometry, data/address widths, row/col marker widths and
//          the FILL/DRAIN state encoding used by the frame streamer.
// Ports:   none (package)
package median_pkg;

    localparam int IMG_W  = 64;
    localparam int IMG_H  = 64;
    localparam int PIXELS = IMG_W * IMG_H;
    localparam int ADDR_W = 13;
    localparam int DATA_W = 8;
    localparam int RC_W   = 6;

    localparam logic ST_FILL  = 1'b0;
    localparam logic ST_DRAIN = 1'b1;

endpackage

// File: rtl/frame_ram.sv
// rtl/frame_ram.sv - simple dual-port frame store, synchronous read
// Purpose: DEPTH x DW pixel memory with one write port and one registered
//          read port (1-cycle latency). Contents are never reset.
// Ports:   clk_i                      clock
//          we_i, waddr_i, wdata_i     write port
//          re_i, raddr_i, rdata_o     read port; rdata_o holds when re_i=0
module frame_ram #(
    parameter int DEPTH = 4096,
    parameter int AW    = 12,
    parameter int DW    = 8
) (
    input  logic          clk_i,
    input  logic          we_i,
    input  logic [AW-1:0] waddr_i,
    input  logic [DW-1:0] wdata_i,
    input  logic          re_i,
    input  logic [AW-1:0] raddr_i,
    output logic [DW-1:0] rdata_o
);

    logic [DW-1:0] mem_q [DEPTH];

    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
        if (re_i) begin
            rdata_o <= mem_q[raddr_i];
        end
    end

endmodule

// File: rtl/filtered_frame_streamer.sv
// rtl/filtered_frame_streamer.sv - frame store filled by address, drained in raster order
// Purpose: captures filtered pixels written by address; once the last
//          address is written, streams the frame out over valid/ready with
//          row/column and sof/eol/eof markers, then returns to filling.
// Ports:   iClk, iRst_n                  clock, async active-low reset
//          iWrite, iAddrPixel, iPixel    write stream from the filter
//          oFillReady, oOverrun          fill status, sticky write-in-drain flag
//          oValid, iReady, oPixel        output pixel handshake and data
//          oRow, oCol, oSof, oEol, oEof  position markers of the output pixel
//          oFrameDone                    pulse after the last pixel handshake
module filtered_frame_streamer #(
    parameter int IMG_W  = median_pkg::IMG_W,
    parameter int IMG_H  = median_pkg::IMG_H,
    parameter int DATA_W = median_pkg::DATA_W,
    parameter int ADDR_W = median_pkg::ADDR_W
) (
    input  logic                        iClk,
    input  logic                        iRst_n,
    input  logic                        iWrite,
    input  logic [ADDR_W-1:0]           iAddrPixel,
    input  logic [DATA_W-1:0]           iPixel,
    output logic                        oFillReady,
    output logic                        oOverrun,
    output logic                        oValid,
    input  logic                        iReady,
    output logic [DATA_W-1:0]           oPixel,
    output logic [median_pkg::RC_W-1:0] oRow,
    output logic [median_pkg::RC_W-1:0] oCol,
    output logic                        oSof,
    output logic                        oEol,
    output logic                        oEof,
    output logic                        oFrameDone
);

    import median_pkg::*;

    localparam int NPIX = IMG_W * IMG_H;
    localparam int AW   = $clog2(NPIX);
    localparam int CB   = $clog2(IMG_W);
    localparam logic [ADDR_W-1:0] NPIX_A = ADDR_W'(NPIX);
    localparam logic [ADDR_W-1:0] LAST_A = ADDR_W'(NPIX - 1);
    localparam logic [AW-1:0]     LAST_I = AW'(NPIX - 1);
    localparam logic [CB-1:0]     EOL_C  = CB'(IMG_W - 1);

    // One pixel in flight through the output buffer: data plus its raster index.
    typedef struct packed {
        logic              vld;
        logic [DATA_W-1:0] pix;
        logic [AW-1:0]     idx;
    } beat_t;

    logic              state_q, state_d;
    logic [ADDR_W-1:0] iss_ptr_q, iss_ptr_d;
    logic              ram_vld_q;
    logic [AW-1:0]     ram_idx_q;
    beat_t             out_q, out_d, skid_q, skid_d, ram_b;
    logic              done_q, ovr_q;
    logic [DATA_W-1:0] ram_rdata;

    logic       addr_ok, fill_wr, fill_last, pop, eof_pop, issue;
    logic [1:0] occ_next;

    assign addr_ok   = iAddrPixel < NPIX_A;
    assign fill_wr   = (state_q == ST_FILL) && iWrite && addr_ok;
    assign fill_last = fill_wr && (iAddrPixel == LAST_A);
    assign pop       = out_q.vld && iReady;
    assign eof_pop   = pop && (out_q.idx == LAST_I);

    // Occupancy of output + skid after this edge, counting the read already in
    // flight. A new read is only launched if its data is guaranteed a slot, so
    // the two registers absorb any stall without losing a pixel.
    assign occ_next = 2'(out_q.vld) + 2'(skid_q.vld) + 2'(ram_vld_q) - 2'(pop);

    // The final fill write also launches the read of pixel 0 so that the first
    // output appears one cycle after the state change.
    assign issue = fill_last
                || ((state_q == ST_DRAIN) && (iss_ptr_q < NPIX_A) && (occ_next < 2'd2));

    frame_ram #(
        .DEPTH (NPIX),
        .AW    (AW),
        .DW    (DATA_W)
    ) u_ram (
        .clk_i   (iClk),
        .we_i    (fill_wr),
        .waddr_i (iAddrPixel[AW-1:0]),
        .wdata_i (iPixel),
        .re_i    (issue),
        .raddr_i (iss_ptr_q[AW-1:0]),
        .rdata_o (ram_rdata)
    );

    // State register
    always_ff @(posedge iClk or negedge iRst_n) begin
        if (!iRst_n) begin
            state_q <= ST_FILL;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_FILL:  if (fill_last) state_d = ST_DRAIN;
            ST_DRAIN: if (eof_pop)   state_d = ST_FILL;
            default:                 state_d = ST_FILL;
        endcase
    end

    // State outputs
    always_comb begin
        oFillReady = (state_q == ST_FILL);
    end

    always_comb begin
        iss_ptr_d = iss_ptr_q;
        if (eof_pop) begin
            iss_ptr_d = '0;
        end else if (issue) begin
            iss_ptr_d = iss_ptr_q + ADDR_W'(1);
        end
    end

    assign ram_b = {ram_vld_q, ram_rdata, ram_idx_q};

    // Output register is the head of a two-entry queue; skid is the tail.
    // Pop shifts skid forward, arriving read data fills the first free slot.
    always_comb begin
        if (pop) begin
            out_d  = skid_q;
            skid_d = '0;
        end else begin
            out_d  = out_q;
            skid_d = skid_q;
        end
        if (ram_vld_q) begin
            if (!out_d.vld) begin
                out_d = ram_b;
            end else begin
                skid_d = ram_b;
            end
        end
    end

    always_ff @(posedge iClk or negedge iRst_n) begin
        if (!iRst_n) begin
            iss_ptr_q <= '0;
            ram_vld_q <= 1'b0;
            ram_idx_q <= '0;
            out_q     <= '0;
            skid_q    <= '0;
            done_q    <= 1'b0;
            ovr_q     <= 1'b0;
        end else begin
            iss_ptr_q <= iss_ptr_d;
            ram_vld_q <= issue;
            if (issue) begin
                ram_idx_q <= iss_ptr_q[AW-1:0];
            end
            out_q  <= out_d;
            skid_q <= skid_d;
            done_q <= eof_pop;
            if ((state_q == ST_DRAIN) && iWrite && addr_ok) begin
                ovr_q <= 1'b1;
            end
        end
    end

    assign oValid     = out_q.vld;
    assign oPixel     = out_q.pix;
    assign oRow       = RC_W'(out_q.idx >> CB);
    assign oCol       = RC_W'(out_q.idx[CB-1:0]);
    assign oSof       = out_q.vld && (out_q.idx == '0);
    assign oEol       = out_q.vld && (out_q.idx[CB-1:0] == EOL_C);
    assign oEof       = out_q.vld && (out_q.idx == LAST_I);
    assign oFrameDone = done_q;
    assign oOverrun   = ovr_q;

endmodule

// File: tb/tb_filtered_frame_streamer.sv
// tb/tb_filtered_frame_streamer.sv - scoreboard bench for filtered_frame_streamer
module tb_filtered_frame_streamer;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        iWrite = 1'b0;
    logic [12:0] iAddrPixel = '0;
    logic [7:0]  iPixel = '0;
    logic        iReady = 1'b0;
    logic        oFillReady, oOverrun, oValid, oSof, oEol, oEof, oFrameDone;
    logic [7:0]  oPixel;
    logic [5:0]  oRow, oCol;

    always #5 clk = ~clk;

    filtered_frame_streamer dut (
        .iClk       (clk),
        .iRst_n     (rst_n),
        .iWrite     (iWrite),
        .iAddrPixel (iAddrPixel),
        .iPixel     (iPixel),
        .oFillReady (oFillReady),
        .oOverrun   (oOverrun),
        .oValid     (oValid),
        .iReady     (iReady),
        .oPixel     (oPixel),
        .oRow       (oRow),
        .oCol       (oCol),
        .oSof       (oSof),
        .oEol       (oEol),
        .oEof       (oEof),
        .oFrameDone (oFrameDone)
    );

    typedef struct {
        logic [7:0] pix;
        int         idx;
    } exp_t;

    exp_t       exp_q[$];
    logic [7:0] model_mem [4096];
    bit         tb_fill = 1'b1;
    bit         rdy_rand = 1'b0;
    int         checks = 0;
    int         errors = 0;
    int         hs_cnt = 0;
    bit         done_pend = 1'b0;
    bit         cap_v = 1'b0;
    logic [23:0] cap;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Sink readiness: free-running or random per cycle.
    always @(posedge clk) begin
        #1;
        iReady = rdy_rand ? 1'($urandom_range(0, 1)) : 1'b1;
    end

    // Monitor: pops the scoreboard on every handshake, checks stall stability
    // and the frame-done pulse.
    always @(negedge clk) begin
        if (!rst_n) begin
            exp_q.delete();
            done_pend = 1'b0;
            cap_v     = 1'b0;
        end else begin
            if (cap_v) begin
                chk("stall_hold", {oValid, oPixel, oRow, oCol, oSof, oEol, oEof}, cap);
            end
            if (done_pend || oFrameDone) begin
                chk("frame_done_pulse", oFrameDone, done_pend);
                if (done_pend) chk("fill_ready_with_done", oFillReady, 1);
            end
            done_pend = 1'b0;
            if (oValid && iReady) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_pixel actual=%0h expected=none at %0t", oPixel, $time);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    chk("pixel", oPixel, e.pix);
                    chk("row", oRow, e.idx / 64);
                    chk("col", oCol, e.idx % 64);
                    chk("sof", oSof, e.idx == 0);
                    chk("eol", oEol, (e.idx % 64) == 63);
                    chk("eof", oEof, e.idx == 4095);
                    if (e.idx == 4095) done_pend = 1'b1;
                end
                hs_cnt++;
            end
            cap_v = oValid && !iReady;
            cap   = {oValid, oPixel, oRow, oCol, oSof, oEol, oEof};
        end
    end

    // Write one pixel; the reference model only accepts it while filling.
    task automatic wr(input int a, input logic [7:0] v);
        iWrite     = 1'b1;
        iAddrPixel = 13'(a);
        iPixel     = v;
        if (tb_fill && a < 4096) begin
            model_mem[a] = v;
            if (a == 4095) begin
                for (int i = 0; i < 4096; i++) exp_q.push_back('{pix: model_mem[i], idx: i});
                hs_cnt  = 0;
                tb_fill = 1'b0;
            end
        end
        @(posedge clk);
        #1;
        iWrite = 1'b0;
    endtask

    task automatic reset_checks();
        chk("rst_fill_ready", oFillReady, 1);
        chk("rst_valid", oValid, 0);
        chk("rst_pixel", oPixel, 0);
        chk("rst_row", oRow, 0);
        chk("rst_col", oCol, 0);
        chk("rst_sof", oSof, 0);
        chk("rst_eol", oEol, 0);
        chk("rst_eof", oEof, 0);
        chk("rst_frame_done", oFrameDone, 0);
        chk("rst_overrun", oOverrun, 0);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        #1;
        reset_checks();
        repeat (2) @(posedge clk);
        #1;
        rst_n   = 1'b1;
        tb_fill = 1'b1;
    endtask

    // Drain with the sink always ready; called right after the last fill write.
    task automatic run_free(input bit eof_wr);
        int cnt;
        cnt = 0;
        chk("fill_ready_low_in_drain", oFillReady, 0);
        chk("valid_low_first_cycle", oValid, 0);
        @(posedge clk);
        #1;
        chk("valid_second_cycle", oValid, 1);
        chk("sof_first", oSof, 1);
        while (oValid && cnt < 5000) begin
            cnt++;
            if (eof_wr && oEof) begin
                iWrite     = 1'b1;
                iAddrPixel = 13'd7;
                iPixel     = 8'h5A;
            end
            @(posedge clk);
            #1;
            iWrite = 1'b0;
        end
        chk("valid_run_length", cnt, 4096);
        chk("frame_done_after_run", oFrameDone, 1);
        chk("fill_ready_after_run", oFillReady, 1);
        tb_fill = 1'b1;
    endtask

    task automatic drain_wait();
        int n;
        n = 0;
        while (!oFrameDone && n < 30000) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("drain_in_time", n < 30000, 1);
        chk("fill_ready_at_done", oFillReady, 1);
        chk("queue_empty", exp_q.size(), 0);
        tb_fill = 1'b1;
    endtask

    initial begin
        int n;
        repeat (2) @(posedge clk);
        #1;
        reset_checks();
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Out-of-order fill with a terminator write, free-running sink,
        // and a write on the eof handshake edge.
        for (int a = 4094; a >= 0; a--) begin
            wr(a, 8'($urandom));
            if (a == 2000) wr(4096, 8'hEE);
        end
        chk("overrun_after_terminator", oOverrun, 0);
        chk("fill_ready_before_last", oFillReady, 1);
        chk("no_valid_before_last", oValid, 0);
        wr(4095, 8'($urandom));
        run_free(1'b1);
        chk("overrun_eof_edge_write", oOverrun, 1);

        // Raster fill, random backpressure, write during drain.
        do_reset();
        rdy_rand = 1'b1;
        for (int i = 0; i < 4096; i++) wr(i, 8'(i));
        wr(10, 8'hAA);
        chk("overrun_drain_write", oOverrun, 1);
        drain_wait();
        chk("overrun_sticky", oOverrun, 1);
        rdy_rand = 1'b0;

        // Back-to-back frame with inverted data.
        chk("fill_ready_b2b", oFillReady, 1);
        for (int i = 0; i < 4096; i++) wr(i, ~8'(i));
        run_free(1'b0);

        // Reset in the middle of a drain.
        rdy_rand = 1'b1;
        for (int i = 0; i < 4096; i++) wr(i, 8'($urandom));
        n = 0;
        while (hs_cnt < 2000 && n < 10000) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("reached_pixel_2000", hs_cnt >= 2000, 1);
        #2;
        do_reset();
        chk("fill_ready_after_reset", oFillReady, 1);
        chk("valid_after_reset", oValid, 0);

        // Partial refill: untouched addresses keep their old contents.
        for (int k = 0; k < 300; k++) wr(int'($urandom_range(0, 4094)), 8'($urandom));
        wr(4095, 8'($urandom));
        drain_wait();
        rdy_rand = 1'b0;

        repeat (3) @(posedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/filtered_frame_streamer.md
# filtered_frame_streamer

Result-side buffer for the 3x3 rank-order filter path. Captures filtered pixels written by pixel address (the filter's `oWrite` / address / `oMedianValue` stream) into a 64x64 frame store. Once the frame is complete, streams it out in raster order over a valid/ready interface with row, column and frame markers. It replaces the bench-only result array and file dump with synthesizable readout logic.

## Interface
Parameters:
- IMG_W, 64, image width in pixels
- IMG_H, 64, image height in pixels
- DATA_W, 8, pixel width
- ADDR_W, 13, pixel address width; must hold IMG_W*IMG_H as a terminator value

Ports:
- iClk  in  1  single clock, rising edge
- iRst_n  in  1  reset, asynchronous assert, active-low
- iWrite  in  1  write strobe from filter path
- iAddrPixel  in  ADDR_W  raster pixel index for the write
- iPixel  in  DATA_W  filtered pixel value
- oFillReady  out  1  high in FILL; writes are accepted
- oOverrun  out  1  sticky; a write arrived outside FILL
- oValid  out  1  output pixel valid
- iReady  in  1  downstream accepts the output pixel
- oPixel  out  DATA_W  output pixel
- oRow  out  6  row of the output pixel
- oCol  out  6  column of the output pixel
- oSof  out  1  marks pixel (0,0)
- oEol  out  1  marks column IMG_W-1
- oEof  out  1  marks pixel (IMG_H-1, IMG_W-1)
- oFrameDone  out  1  one-cycle pulse after the last pixel handshake

## Operation
- States: FILL, DRAIN. Reset state is FILL.
- **FILL**
  - A write with iWrite=1 and iAddrPixel < PIXELS stores iPixel at that address.
  - Writes may arrive in any order. Repeated addresses overwrite.
  - iAddrPixel >= PIXELS (including the 4096 terminator) is ignored silently and does not set oOverrun.
  - A write to address PIXELS-1 ends FILL. That pixel is stored and the state moves to DRAIN on the same edge.
- **DRAIN**
  - The read pointer runs 0..PIXELS-1 in raster order.
  - oRow = pointer / IMG_W and oCol = pointer % IMG_W, taken from the pointer bits. IMG_W is a power of two.
  - A handshake is oValid & iReady on a rising edge; each handshake advances the pointer.
  - While oValid=1 and iReady=0, oPixel, oRow, oCol and all markers hold stable.
  - A write in DRAIN with iAddrPixel < PIXELS is dropped, leaves memory unchanged, and sets oOverrun.
  - Handshake of the oEof pixel: the next state is FILL, oValid drops, and oFrameDone pulses for one cycle.
- oOverrun clears only on reset.
- Memory contents are not cleared by reset or by a frame change. Unwritten addresses read back stale data.

## Timing
- Reset values: state FILL, pointer 0, oFillReady=1, oValid=0, oPixel=0, oRow=0, oCol=0, oSof=oEol=oEof=0, oFrameDone=0, oOverrun=0.
- Memory read is synchronous, 1-cycle latency.
- Last-address write at edge N:
  - State becomes DRAIN at N; oFillReady=0 from N.
  - oValid=1 with pixel 0 and oSof from edge N+1.
- Throughput is one pixel per cycle while iReady stays high. There are no bubbles, including across row boundaries and across iReady stalls; implementation uses a prefetch/skid register.
- Full frame with iReady tied high: PIXELS consecutive valid cycles. oFrameDone is asserted in the cycle after the oEof handshake; oFillReady=1 in that same cycle.
- Write coinciding with the oEof handshake edge: the state is still DRAIN, so the write is dropped and oOverrun is set.
- Reset asserted mid-DRAIN: outputs go to reset values asynchronously. After release, the block is in FILL with pointer 0.
- iReady changing while oValid=0 has no effect.

## Structure
- Shared package `median_pkg`:
  - IMG_W, IMG_H, PIXELS, ADDR_W, DATA_W constants
  - state encoding localparams FILL/DRAIN
  - row/col width constants (6)
- Sub-module `frame_ram`: simple dual-port memory, 1 write port, 1 synchronous read port, PIXELS x DATA_W, no reset.
- Top level holds: FSM, read pointer, prefetch/skid pair, marker decode, overrun flag.

## Test plan
- **Raster fill, free-running sink:** write pixel[i] = i[7:0] for i = 0..4095, iReady=1 → 4096 consecutive oValid cycles with oPixel = i[7:0]; oSof only at i=0; oEol at col 63; oEof at i=4095; oFrameDone one cycle later.
- **Backpressure:** iReady toggles 1,0,0,1 pseudo-randomly → no pixel lost or duplicated; outputs stable across each stall; sequence still 0..4095.
- **Out-of-order fill:** write addresses 4094 down to 0, then 4095, plus a write to 4096 → DRAIN starts only after 4095; the 4096 write is ignored with oOverrun=0; output is correct.
- **Overrun:** write address 10 value 0xAA during DRAIN → oOverrun=1 and stays 1; drained pixel 10 keeps its FILL value. Also a write on the same edge as the oEof handshake → dropped and flagged.
- **Back-to-back frames:** second frame with pixel = ~i → second drain outputs ~i[7:0]; oFillReady rises exactly with oFrameDone.
- **Reset mid-DRAIN at pixel 2000:** oValid=0 and all outputs 0 immediately; oFillReady=1 after release; a refill then drains correctly from pixel 0.
